coproc_tile_dispatcher: RTL and testbench
=========================================

// Module: coproc_tile_dispatcher
// PURPOSE
//  Hardware host sequencer for NUM_CH matrix coprocessor channels. Reads the config word from memory,
//  walks tile indices (row 0..lambda-1, col 0..gamma-1, col inner) and hands each tile to a free channel.
//  Arbitrates all channel memory traffic onto one memory port. Sits between the processor array and memory.
// PARAMETERS
//  NUM_CH          2    processor channels, 1..8
//  size            3    cells per memory row
//  cell_width      32   bits per cell
//  width           96   cell_width*size, memory data width
//  index_width     8    row/col/mu index width
//  memory_size_log 8    memory address width
//  CONFIG_ADDR     0    address of config word (cell 0: mu[23:16], gamma[15:8], lambda[7:0])
// PORTS
//  in_clk              in   1                      clock, rising edge
//  in_reset            in   1                      async reset, active low
//  in_start            in   1                      1-cycle pulse starts a job; ignored unless IDLE/DONE
//  out_busy            out  1                      high from start until DONE
//  out_done            out  1                      high in DONE, cleared by next start
//  out_config          out  cell_width             latched config word
//  out_tile_count      out  2*index_width          tiles completed
//  out_mem_address     out  memory_size_log        memory address
//  out_mem_data        out  width                  memory write data
//  out_mem_read_en     out  1                      memory read strobe
//  out_mem_write_en    out  1                      memory write strobe
//  in_mem_data         in   width                  memory read data, valid 1 cycle after read_en
//  out_ch_mem_data     out  width                  in_mem_data broadcast to all channels
//  in_ch_request       in   NUM_CH                 per-channel bus request
//  out_ch_grant        out  NUM_CH                 per-channel grant, one-hot or zero
//  in_ch_mem_read_en   in   NUM_CH                 per-channel read strobe
//  in_ch_mem_write_en  in   NUM_CH                 per-channel write strobe
//  in_ch_mem_address   in   NUM_CH*memory_size_log channel k at [k*memory_size_log +: memory_size_log]
//  in_ch_mem_data      in   NUM_CH*width           channel write data, same packing
//  out_ch_row_index    out  NUM_CH*index_width     tile row per channel
//  out_ch_col_index    out  NUM_CH*index_width     tile col per channel
//  out_ch_mu           out  index_width            mu, broadcast
//  out_ch_index_ready  out  NUM_CH                 tile valid per channel
//  in_ch_index_ack     in   NUM_CH                 channel accepted tile (informational; counted in debug only)
//  in_ch_result_ready  in   NUM_CH                 channel finished tile
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; arbiter pointer 0; all channels free.
//  FSM: IDLE -start-> CFG_RD (read_en=1, address=CONFIG_ADDR, 1 cycle) -> CFG_WAIT (latch in_mem_data[cell_width-1:0])
//   -> DISPATCH; lambda==0 or gamma==0 -> DONE directly, tile_count=0.
//   DISPATCH -> DRAIN when last tile assigned; DRAIN -> DONE (or STATUS_WR) when all channels free.
//  Dispatch: at most one assignment per cycle, to the lowest-numbered free channel; drive row/col, set index_ready.
//   index_ready held until in_ch_result_ready of that channel; then index_ready=0 for >=1 cycle, tile_count+1,
//   channel free the following cycle. A result_ready on a non-busy channel is ignored.
//  Indices: col increments to gamma-1 then wraps to 0 with row+1; last tile is (lambda-1, gamma-1).
//  Arbiter: round-robin from the channel after the last granted one; grant asserted the cycle after request,
//   held while request stays high; released the cycle request drops; min 1 idle cycle between grants.
//   Memory port muxed from the granted channel; no grant -> read_en=write_en=0, address/data 0.
//   During CFG_RD the dispatcher owns the port; grants are 0.
//   Granted channel with read_en and write_en both high: write wins, read suppressed.
//  Read data: in_mem_data forwarded combinationally to out_ch_mem_data (zero added latency).
//  Start while busy: ignored. Reset mid-job: abort, all outputs 0, job is not resumed.
// CONFIGURATION
//  STATUS_WRITEBACK_EN defined: DRAIN -> STATUS_WR, 1 cycle, out_write_status_en=1,
//   out_status={8'h01, tile_count[23:0]}; outputs zero otherwise.
//  Undefined: ports out_status/out_write_status_en absent; DRAIN -> DONE.
// STRUCTURE
//  Shared package coproc_pkg: FSM state encodings, config field offsets (MU/GAMMA/LAMBDA lsb), status tag.
//  Sub-module coproc_rr_arbiter (NUM_CH requests -> one-hot grant, lock while held).
// TESTING
//  Config 0x00_03_02_02 (mu=3, gamma=2, lambda=2), NUM_CH=2, ideal channel models -> tiles (0,0),(0,1),(1,0),(1,1)
//   each dispatched once; out_done, out_tile_count=4.
//  Config lambda=0 -> DONE within 3 cycles of start; no index_ready, tile_count=0.
//  Both channels request on the same cycle, pointer 0 -> ch0 granted; ch0 drops -> ch1 granted after 1 idle cycle.
//  Channel asserts read_en+write_en at address 0x12 -> only write_en seen at memory; data = channel data.
//  Reset pulled low mid-DISPATCH (tile 2 of 4) -> all outputs 0 immediately; restart recomputes tile_count=4.
//  STATUS_WRITEBACK_EN with the 4-tile job -> single cycle out_write_status_en, out_status=0x01000004.

Source files
------------

// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor tile dispatcher: FSM state encoding,
// config word field positions and the status write-back tag.
package coproc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CFG_RD    = 3'd1,
        ST_CFG_WAIT  = 3'd2,
        ST_DISPATCH  = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_STATUS_WR = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

    // Config word layout: mu[23:16], gamma[15:8], lambda[7:0]
    localparam int CFG_FIELD_W = 8;
    localparam int MU_LSB      = 16;
    localparam int GAMMA_LSB   = 8;
    localparam int LAMBDA_LSB  = 0;

    localparam logic [7:0] STATUS_TAG = 8'h01;

    // Extract one 8-bit field from the config word
    function automatic logic [CFG_FIELD_W-1:0] cfg_field(input logic [31:0] cfg, input int lsb);
        return cfg[lsb +: CFG_FIELD_W];
    endfunction

endpackage

// File: rtl/coproc_rr_arbiter.sv
// Round-robin bus arbiter: NUM_CH requests -> one-hot grant.
// A grant is held while its request stays high and vanishes in the same cycle
// the request drops; the search for the next owner starts after the last winner.
// 'block' hides all grants (the dispatcher owns the port that cycle).
module coproc_rr_arbiter
#(
    parameter int NUM_CH = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              block,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant
);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic              found_s;
    int                idx_s;

    // Keep a live grant, otherwise scan requests starting at the pointer
    always_comb begin
        grant_d = grant_q;
        ptr_d   = ptr_q;
        found_s = 1'b0;
        idx_s   = 0;
        if (block) begin
            grant_d = '0;
        end else if ((grant_q & req) != '0) begin
            grant_d = grant_q;
        end else begin
            grant_d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                idx_s = (int'(ptr_q) + i) % NUM_CH;
                if (!found_s && req[idx_s]) begin
                    found_s        = 1'b1;
                    grant_d[idx_s] = 1'b1;
                    ptr_d          = PW'((idx_s + 1) % NUM_CH);
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Grant and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // A dropped request releases its grant immediately
    assign grant = grant_q & req & {NUM_CH{~block}};

endmodule

// File: rtl/coproc_tile_dispatcher.sv
// Host sequencer for NUM_CH matrix coprocessor channels: fetches the config word,
// walks the lambda x gamma tile grid (column inner) handing tiles to free channels,
// and arbitrates channel memory traffic onto the single memory port.
// Optional build macro: STATUS_WRITEBACK_EN adds a one-cycle status report
// (out_status / out_write_status_en) between DRAIN and DONE.
module coproc_tile_dispatcher
    import coproc_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int size            = 3,
    parameter int cell_width      = 32,
    parameter int width           = cell_width * size,
    parameter int index_width     = 8,
    parameter int memory_size_log = 8,
    parameter int CONFIG_ADDR     = 0
)(
    input  logic                              in_clk,
    input  logic                              in_reset,
    input  logic                              in_start,
    output logic                              out_busy,
    output logic                              out_done,
    output logic [cell_width-1:0]             out_config,
    output logic [2*index_width-1:0]          out_tile_count,
    output logic [memory_size_log-1:0]        out_mem_address,
    output logic [width-1:0]                  out_mem_data,
    output logic                              out_mem_read_en,
    output logic                              out_mem_write_en,
    input  logic [width-1:0]                  in_mem_data,
    output logic [width-1:0]                  out_ch_mem_data,
    input  logic [NUM_CH-1:0]                 in_ch_request,
    output logic [NUM_CH-1:0]                 out_ch_grant,
    input  logic [NUM_CH-1:0]                 in_ch_mem_read_en,
    input  logic [NUM_CH-1:0]                 in_ch_mem_write_en,
    input  logic [NUM_CH*memory_size_log-1:0] in_ch_mem_address,
    input  logic [NUM_CH*width-1:0]           in_ch_mem_data,
    output logic [NUM_CH*index_width-1:0]     out_ch_row_index,
    output logic [NUM_CH*index_width-1:0]     out_ch_col_index,
    output logic [index_width-1:0]            out_ch_mu,
    output logic [NUM_CH-1:0]                 out_ch_index_ready,
    input  logic [NUM_CH-1:0]                 in_ch_index_ack,
    input  logic [NUM_CH-1:0]                 in_ch_result_ready
`ifdef STATUS_WRITEBACK_EN
    ,
    output logic [31:0]                       out_status,
    output logic                              out_write_status_en
`endif
);
    localparam int IW  = index_width;
    localparam int MSL = memory_size_log;
    localparam int TCW = 2 * index_width;

    state_e                 state_q, state_d;
    logic [cell_width-1:0]  config_q, config_d;
    logic [TCW-1:0]         tile_count_q, tile_count_d;
    logic [IW-1:0]          row_q, row_d, col_q, col_d;
    logic [NUM_CH-1:0]      ch_ready_q, ch_ready_d;
    logic [NUM_CH-1:0]      ch_busy_q, ch_busy_d;
    logic [NUM_CH*IW-1:0]   ch_row_q, ch_row_d, ch_col_q, ch_col_d;
    logic                   assigned_s;
    logic [IW-1:0]          lambda_s, gamma_s;
    logic [NUM_CH-1:0]      grant_s;
    logic                   unused_ack_s;

    assign lambda_s = cfg_field(config_q[31:0], LAMBDA_LSB);
    assign gamma_s  = cfg_field(config_q[31:0], GAMMA_LSB);

    // Acknowledge is informational only; the channel is tracked via index_ready/result_ready
    assign unused_ack_s = ^in_ch_index_ack;

    coproc_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk   (in_clk),
        .rst_n (in_reset),
        .block (state_q == ST_CFG_RD),
        .req   (in_ch_request),
        .grant (grant_s)
    );

    // Sequencer next state: channel lifecycle, tile walk and job FSM
    always_comb begin
        state_d      = state_q;
        config_d     = config_q;
        tile_count_d = tile_count_q;
        row_d        = row_q;
        col_d        = col_q;
        ch_ready_d   = ch_ready_q;
        ch_busy_d    = ch_busy_q;
        ch_row_d     = ch_row_q;
        ch_col_d     = ch_col_q;
        assigned_s   = 1'b0;

        // Channel: ready -> (result) release cycle -> free on the next cycle
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_ready_q[k]) begin
                if (in_ch_result_ready[k]) begin
                    ch_ready_d[k] = 1'b0;
                    tile_count_d  = tile_count_d + TCW'(1);
                end else begin
                    ch_ready_d[k] = 1'b1;
                end
            end else if (ch_busy_q[k]) begin
                ch_busy_d[k] = 1'b0;
            end else begin
                ch_busy_d[k] = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (in_start) begin
                    state_d      = ST_CFG_RD;
                    tile_count_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_CFG_RD: begin
                state_d = ST_CFG_WAIT;
            end
            ST_CFG_WAIT: begin
                config_d = in_mem_data[cell_width-1:0];
                row_d    = '0;
                col_d    = '0;
                if (cfg_field(in_mem_data[31:0], LAMBDA_LSB) == 8'd0 ||
                    cfg_field(in_mem_data[31:0], GAMMA_LSB) == 8'd0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                // One tile per cycle, lowest-numbered free channel first
                for (int k = 0; k < NUM_CH; k++) begin
                    if (!assigned_s && !ch_busy_q[k]) begin
                        assigned_s           = 1'b1;
                        ch_busy_d[k]         = 1'b1;
                        ch_ready_d[k]        = 1'b1;
                        ch_row_d[k*IW +: IW] = row_q;
                        ch_col_d[k*IW +: IW] = col_q;
                    end else begin
                        assigned_s = assigned_s;
                    end
                end
                if (assigned_s) begin
                    if (row_q == lambda_s - IW'(1) && col_q == gamma_s - IW'(1)) begin
                        state_d = ST_DRAIN;
                    end else if (col_q == gamma_s - IW'(1)) begin
                        col_d = '0;
                        row_d = row_q + IW'(1);
                    end else begin
                        col_d = col_q + IW'(1);
                    end
                end else begin
                    state_d = ST_DISPATCH;
                end
            end
            ST_DRAIN: begin
                if (ch_busy_q == '0) begin
`ifdef STATUS_WRITEBACK_EN
                    state_d = ST_STATUS_WR;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_STATUS_WR: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset aborts any job in flight
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q      <= ST_IDLE;
            config_q     <= '0;
            tile_count_q <= '0;
            row_q        <= '0;
            col_q        <= '0;
            ch_ready_q   <= '0;
            ch_busy_q    <= '0;
            ch_row_q     <= '0;
            ch_col_q     <= '0;
        end else begin
            state_q      <= state_d;
            config_q     <= config_d;
            tile_count_q <= tile_count_d;
            row_q        <= row_d;
            col_q        <= col_d;
            ch_ready_q   <= ch_ready_d;
            ch_busy_q    <= ch_busy_d;
            ch_row_q     <= ch_row_d;
            ch_col_q     <= ch_col_d;
        end
    end

    // Memory port mux: config fetch owns the port, otherwise the granted channel; write beats read
    always_comb begin
        out_mem_address  = '0;
        out_mem_data     = '0;
        out_mem_read_en  = 1'b0;
        out_mem_write_en = 1'b0;
        if (state_q == ST_CFG_RD) begin
            out_mem_address = MSL'(CONFIG_ADDR);
            out_mem_read_en = 1'b1;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (grant_s[k]) begin
                    out_mem_address  = in_ch_mem_address[k*MSL +: MSL];
                    out_mem_data     = in_ch_mem_data[k*width +: width];
                    out_mem_write_en = in_ch_mem_write_en[k];
                    out_mem_read_en  = in_ch_mem_read_en[k] & ~in_ch_mem_write_en[k];
                end else begin
                    out_mem_read_en = out_mem_read_en;
                end
            end
        end
    end

`ifdef STATUS_WRITEBACK_EN
    // Status word is only presented during the single write-back cycle
    always_comb begin
        out_status          = 32'h0000_0000;
        out_write_status_en = 1'b0;
        if (state_q == ST_STATUS_WR) begin
            out_status          = {STATUS_TAG, 24'(tile_count_q)};
            out_write_status_en = 1'b1;
        end else begin
            out_write_status_en = 1'b0;
        end
    end
`endif

    assign out_busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign out_done           = (state_q == ST_DONE);
    assign out_config         = config_q;
    assign out_tile_count     = tile_count_q;
    assign out_ch_mem_data    = in_mem_data;
    assign out_ch_grant       = grant_s;
    assign out_ch_row_index   = ch_row_q;
    assign out_ch_col_index   = ch_col_q;
    assign out_ch_mu          = config_q[MU_LSB +: IW];
    assign out_ch_index_ready = ch_ready_q;

endmodule

// File: tb/tb_coproc_tile_dispatcher.sv
// Self-checking bench for coproc_tile_dispatcher (NUM_CH=2 default build;
// status write-back checks are included when STATUS_WRITEBACK_EN is defined).
module tb_coproc_tile_dispatcher;
    localparam int NCH = 2;
    localparam int IW  = 8;
    localparam int MSL = 8;
    localparam int CW  = 32;
    localparam int W   = 96;

    logic               in_clk = 1'b0;
    logic               in_reset = 1'b0;
    logic               in_start = 1'b0;
    logic               out_busy, out_done;
    logic [CW-1:0]      out_config;
    logic [2*IW-1:0]    out_tile_count;
    logic [MSL-1:0]     out_mem_address;
    logic [W-1:0]       out_mem_data;
    logic               out_mem_read_en, out_mem_write_en;
    logic [W-1:0]       in_mem_data;
    logic [W-1:0]       out_ch_mem_data;
    logic [NCH-1:0]     in_ch_request = '0;
    logic [NCH-1:0]     out_ch_grant;
    logic [NCH-1:0]     in_ch_mem_read_en = '0;
    logic [NCH-1:0]     in_ch_mem_write_en = '0;
    logic [NCH*MSL-1:0] in_ch_mem_address = '0;
    logic [NCH*W-1:0]   in_ch_mem_data = '0;
    logic [NCH*IW-1:0]  out_ch_row_index, out_ch_col_index;
    logic [IW-1:0]      out_ch_mu;
    logic [NCH-1:0]     out_ch_index_ready;
    logic [NCH-1:0]     in_ch_index_ack = '0;
    logic [NCH-1:0]     in_ch_result_ready = '0;
`ifdef STATUS_WRITEBACK_EN
    logic [31:0]        out_status;
    logic               out_write_status_en;
    int                 st_pulses;
    logic [31:0]        st_val;
`endif

    coproc_tile_dispatcher dut (
        .in_clk(in_clk), .in_reset(in_reset), .in_start(in_start),
        .out_busy(out_busy), .out_done(out_done), .out_config(out_config),
        .out_tile_count(out_tile_count), .out_mem_address(out_mem_address),
        .out_mem_data(out_mem_data), .out_mem_read_en(out_mem_read_en),
        .out_mem_write_en(out_mem_write_en), .in_mem_data(in_mem_data),
        .out_ch_mem_data(out_ch_mem_data), .in_ch_request(in_ch_request),
        .out_ch_grant(out_ch_grant), .in_ch_mem_read_en(in_ch_mem_read_en),
        .in_ch_mem_write_en(in_ch_mem_write_en), .in_ch_mem_address(in_ch_mem_address),
        .in_ch_mem_data(in_ch_mem_data), .out_ch_row_index(out_ch_row_index),
        .out_ch_col_index(out_ch_col_index), .out_ch_mu(out_ch_mu),
        .out_ch_index_ready(out_ch_index_ready), .in_ch_index_ack(in_ch_index_ack),
        .in_ch_result_ready(in_ch_result_ready)
`ifdef STATUS_WRITEBACK_EN
        , .out_status(out_status), .out_write_status_en(out_write_status_en)
`endif
    );

    always #5 in_clk = ~in_clk;

    // Memory model: registered read, data valid the cycle after read_en
    logic [CW-1:0] cfg_word = 32'h0;
    logic [W-1:0]  rdata_q;
    always @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) rdata_q <= '0;
        else if (out_mem_read_en)
            rdata_q <= (out_mem_address == 8'h00) ? {64'h0, cfg_word} : {88'h0, out_mem_address};
    end
    assign in_mem_data = rdata_q;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Ideal channel model state
    int seen[NCH];
    int cnt[NCH];
    int disp_cnt[64];
    int n_disp;
    int bad_idx;

    task automatic reset_model();
        for (int k = 0; k < NCH; k++) begin seen[k] = 0; cnt[k] = 0; end
        for (int i = 0; i < 64; i++) disp_cnt[i] = 0;
        n_disp = 0;
        bad_idx = 0;
`ifdef STATUS_WRITEBACK_EN
        st_pulses = 0;
        st_val = 32'h0;
`endif
    endtask

    task automatic pulse_start();
        @(negedge in_clk); in_start = 1'b1;
        @(negedge in_clk); in_start = 1'b0;
    endtask

    // Drive ideal channels until done, stop_after dispatches (if >0), or budget expiry
    task automatic run_job(input int stop_after, input int budget, output bit finished);
        int r, c;
        finished = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge in_clk);
            in_ch_result_ready = '0;
            for (int k = 0; k < NCH; k++) begin
                if (out_ch_index_ready[k]) begin
                    if (seen[k] == 0) begin
                        seen[k] = 1;
                        cnt[k]  = 2 + k;
                        r = int'(out_ch_row_index[k*IW +: IW]);
                        c = int'(out_ch_col_index[k*IW +: IW]);
                        if (r < 8 && c < 8) disp_cnt[r*8 + c]++;
                        else bad_idx++;
                        n_disp++;
                    end else begin
                        cnt[k]--;
                        if (cnt[k] == 0) in_ch_result_ready[k] = 1'b1;
                    end
                end else begin
                    seen[k] = 0;
                end
            end
`ifdef STATUS_WRITEBACK_EN
            if (out_write_status_en) begin st_pulses++; st_val = out_status; end
`endif
            if (out_done) begin finished = 1'b1; return; end
            if (stop_after > 0 && n_disp >= stop_after) begin finished = 1'b1; return; end
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {out_busy, out_done, out_config, out_tile_count, out_mem_address,
                               out_mem_read_en, out_mem_write_en, out_ch_grant, out_ch_index_ready,
                               out_ch_mu, out_ch_row_index, out_ch_col_index}, 128'h0);
        check({name, "_wdata"}, out_mem_data, 128'h0);
        check({name, "_rdata"}, out_ch_mem_data, 128'h0);
    endtask

    typedef struct {
        logic [31:0] cfg;
        int          exp_tiles;
    } job_t;
    job_t jobs[7];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        bit fin;
        int ok_tiles;
        logic [7:0] lam, gam;

        jobs[0] = '{32'h0003_0202, 4};
        jobs[1] = '{32'h0005_0101, 1};
        jobs[2] = '{32'h0007_0301, 3};
        jobs[3] = '{32'h0002_0103, 3};
        jobs[4] = '{32'h0009_0302, 6};
        jobs[5] = '{32'h0001_0200, 0};
        jobs[6] = '{32'h0001_0002, 0};

        // Reset state
        repeat (3) @(negedge in_clk);
        check_all_zero("reset");
        in_reset = 1'b1;

        // Arbiter: simultaneous requests, pointer 0, hold, release, round-robin
        @(negedge in_clk); in_ch_request = 2'b11;
        #1 check("arb_same_cycle", out_ch_grant, 2'b00);
        @(negedge in_clk); check("arb_first_ch0", out_ch_grant, 2'b01);
        @(negedge in_clk); check("arb_hold_ch0", out_ch_grant, 2'b01);
        in_ch_request = 2'b10;
        #1 check("arb_release_ch0", out_ch_grant, 2'b00);
        @(negedge in_clk); check("arb_next_ch1", out_ch_grant, 2'b10);
        in_ch_request = 2'b00;
        #1 check("arb_release_ch1", out_ch_grant, 2'b00);

        // Memory mux: no grant -> all zero; read+write on the granted channel -> write only
        @(negedge in_clk);
        in_ch_mem_address  = {8'h34, 8'h12};
        in_ch_mem_data     = {96'hBBBB_0000_1111_2222_3333_4444, 96'hAAAA_5555_6666_7777_8888_9999};
        in_ch_mem_read_en  = 2'b11;
        in_ch_mem_write_en = 2'b01;
        #1 check("mux_nogrant", {out_mem_address, out_mem_read_en, out_mem_write_en, out_mem_data}, 128'h0);
        in_ch_request = 2'b01;
        @(negedge in_clk);
        check("rw_grant", out_ch_grant, 2'b01);
        check("rw_write_en", {out_mem_write_en, out_mem_read_en}, 2'b10);
        check("rw_addr", out_mem_address, 8'h12);
        check("rw_data", out_mem_data, 96'hAAAA_5555_6666_7777_8888_9999);
        in_ch_request = 2'b00;

        // lambda=0: config fetch owns the port, DONE within 3 cycles, no tiles
        cfg_word = 32'h0003_0200;
        @(negedge in_clk); in_start = 1'b1; in_ch_request = 2'b01;
        @(negedge in_clk); in_start = 1'b0;
        check("cfgrd_port", {out_mem_read_en, out_mem_write_en, out_mem_address}, {2'b10, 8'h00});
        check("cfgrd_grant", out_ch_grant, 2'b00);
        check("cfgrd_busy", out_busy, 1'b1);
        @(negedge in_clk);
        check("cfgwait_fwd", out_ch_mem_data, {64'h0, 32'h0003_0200});
        check("cfgwait_ready", out_ch_index_ready, 2'b00);
        @(negedge in_clk);
        check("zero_done", {out_done, out_busy}, 2'b10);
        check("zero_tiles", {out_tile_count, out_ch_index_ready}, 18'h0);
        in_ch_request = 2'b00; in_ch_mem_read_en = 2'b00; in_ch_mem_write_en = 2'b00;

        // Table-driven jobs with ideal channels
        for (int j = 0; j < 7; j++) begin
            cfg_word = jobs[j].cfg;
            lam = jobs[j].cfg[7:0];
            gam = jobs[j].cfg[15:8];
            reset_model();
            pulse_start();
            run_job(0, 300, fin);
            check($sformatf("job%0d_done", j), {fin, out_done, out_busy}, 3'b110);
            check($sformatf("job%0d_count", j), out_tile_count, 16'(jobs[j].exp_tiles));
            check($sformatf("job%0d_config", j), {out_config, out_ch_mu}, {jobs[j].cfg, jobs[j].cfg[23:16]});
            ok_tiles = 0;
            for (int r = 0; r < int'(lam); r++)
                for (int c = 0; c < int'(gam); c++)
                    if (disp_cnt[r*8 + c] == 1) ok_tiles++;
            check($sformatf("job%0d_tiles", j), {32'(n_disp), 32'(ok_tiles), 32'(bad_idx)},
                  {32'(jobs[j].exp_tiles), 32'(jobs[j].exp_tiles), 32'h0});
`ifdef STATUS_WRITEBACK_EN
            if (j == 0) check("status_wb", {32'(st_pulses), st_val}, {32'h1, 32'h0100_0004});
`endif
        end

        // Reset mid-DISPATCH after tile 2 is handed out, then rerun
        cfg_word = 32'h0003_0202;
        reset_model();
        pulse_start();
        run_job(3, 300, fin);
        check("mid_reached", {fin, out_busy, out_done}, 3'b110);
        in_reset = 1'b0;
        in_ch_result_ready = '0;
        #1 check_all_zero("mid_reset");
        @(negedge in_clk); in_reset = 1'b1;
        reset_model();
        pulse_start();
        run_job(0, 300, fin);
        check("restart_done", {fin, out_done}, 2'b11);
        check("restart_count", {out_tile_count, 32'(n_disp)}, {16'd4, 32'd4});

        // Spurious result_ready while no channel is busy must be ignored
        @(negedge in_clk); in_ch_result_ready = 2'b11;
        @(negedge in_clk); in_ch_result_ready = 2'b00;
        @(negedge in_clk);
        check("spurious_result", {out_tile_count, out_ch_index_ready, out_done}, {16'd4, 2'b00, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
